// File: rtl/cu_mc.sv
// cu_mc: multi-cycle control unit for mycpu (fetch/execute sequencing, ready
// handshakes with watchdog, single-level vectored interrupt). Rev 1.0
`default_nettype none

package mycpu_pkg;
  typedef enum logic [6:0] {
    OP_ADD = 7'h02,
    OP_SUB = 7'h03,
    OP_AND = 7'h08,
    OP_XOR = 7'h0A,
    OP_LD  = 7'h10,
    OP_IOR = 7'h11,
    OP_ST  = 7'h20,
    OP_IOW = 7'h21,
    OP_ADI = 7'h42,
    OP_JMP = 7'h44,
    OP_RTI = 7'h45,
    OP_LDI = 7'h4C,
    OP_XXL = 7'h50,
    OP_BRZ = 7'h60,
    OP_BRN = 7'h61,
    OP_HAL = 7'h7F
  } opcode_t;
endpackage

module cu_mc
  import mycpu_pkg::*;
#(
  parameter int RA_W    = 3,
  parameter int TIMEOUT = 255,
  localparam int IW     = 7 + 3*RA_W,
  localparam int CW     = $clog2(TIMEOUT+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IW-1:0]         ins_in,
  input  logic                  z_in,
  input  logic                  n_in,
  input  logic                  mem_rdy_in,
  input  logic                  io_rdy_in,
  input  logic                  irq_in,
  input  logic                  irq_en_in,
  output logic                  il_out,
  output logic [1:0]            ps_out,
  output logic                  rw_out,
  output logic [3*(RA_W+1)-1:0] rs_out,
  output logic                  mm_out,
  output logic [1:0]            md_out,
  output logic                  mb_out,
  output logic [3:0]            fs_out,
  output logic                  wen_out,
  output logic                  iom_out,
  output logic                  pc_vec_out,
  output logic                  pc_epc_out,
  output logic                  epc_we_out,
  output logic                  irq_ack_out,
  output logic                  halted_out,
  output logic                  err_out
);

  localparam logic [2:0] S_RST = 3'd0;
  localparam logic [2:0] S_INF = 3'd1;
  localparam logic [2:0] S_EX0 = 3'd2;
  localparam logic [2:0] S_XL1 = 3'd3;
  localparam logic [2:0] S_INT = 3'd4;
  localparam logic [2:0] S_HLT = 3'd5;

  localparam logic [RA_W:0] TMP   = '1;
  localparam logic [RA_W:0] R_ZER = '0;
  localparam logic [RA_W:0] R_ONE = (RA_W+1)'(1);
  localparam logic [RA_W:0] R_TWO = (RA_W+1)'(2);
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);

  logic [2:0]      state, nstate;
  logic            isr_r, err_r;
  logic [CW-1:0]   wcnt;
  logic            isr_set, isr_clr, err_set, wait_cyc;
  logic            wait_op, wb_op, rdy;
  logic [6:0]      opcode;
  logic [RA_W-1:0] fa, fb, fc;
  logic            irq_ok;

  assign opcode = ins_in[IW-1:IW-7];
  assign fa     = ins_in[3*RA_W-1:2*RA_W];
  assign fb     = ins_in[2*RA_W-1:RA_W];
  assign fc     = ins_in[RA_W-1:0];
  assign irq_ok = irq_in & irq_en_in & ~isr_r;

  assign halted_out = (state == S_HLT);
  assign err_out    = err_r;

  always_comb begin
    il_out      = 1'b0;
    ps_out      = 2'd0;
    rw_out      = 1'b0;
    rs_out      = '0;
    mm_out      = 1'b0;
    md_out      = 2'd0;
    mb_out      = 1'b0;
    fs_out      = 4'd0;
    wen_out     = 1'b1;
    iom_out     = 1'b0;
    pc_vec_out  = 1'b0;
    pc_epc_out  = 1'b0;
    epc_we_out  = 1'b0;
    irq_ack_out = 1'b0;
    nstate      = state;
    wait_cyc    = 1'b0;
    isr_set     = 1'b0;
    isr_clr     = 1'b0;
    err_set     = 1'b0;
    wait_op     = 1'b0;
    wb_op       = 1'b0;
    rdy         = 1'b0;

    case (state)
      S_RST: nstate = S_INF;
      S_INF: begin
        if (irq_ok) begin
          nstate = S_INT;
        end else begin
          mm_out = 1'b1;
          il_out = mem_rdy_in;
          if (mem_rdy_in) nstate = S_EX0;
          else            wait_cyc = 1'b1;
        end
      end
      S_EX0: begin
        fs_out = opcode[3:0];
        rs_out = {1'b0, fa, 1'b0, fb, 1'b0, fc};
        if (opcode[6:4] == 3'b000) begin
          rw_out = 1'b1;
          ps_out = 2'd1;
          nstate = S_INF;
        end else begin
          case (opcode)
            OP_LDI, OP_ADI: begin
              rw_out = 1'b1;
              ps_out = 2'd1;
              mb_out = 1'b1;
              nstate = S_INF;
            end
            OP_LD: begin
              md_out  = 2'd1;
              wait_op = 1'b1;
              wb_op   = 1'b1;
              rdy     = mem_rdy_in;
            end
            OP_ST: begin
              wen_out = 1'b0;
              wait_op = 1'b1;
              rdy     = mem_rdy_in;
            end
            OP_IOR: begin
              md_out  = 2'd2;
              iom_out = 1'b1;
              fs_out  = 4'd0;
              wait_op = 1'b1;
              wb_op   = 1'b1;
              rdy     = io_rdy_in;
            end
            OP_IOW: begin
              wen_out = 1'b0;
              iom_out = 1'b1;
              fs_out  = 4'd0;
              wait_op = 1'b1;
              rdy     = io_rdy_in;
            end
            OP_BRZ: begin
              ps_out = z_in ? 2'd2 : 2'd1;
              fs_out = 4'd0;
              nstate = S_INF;
            end
            OP_BRN: begin
              ps_out = n_in ? 2'd2 : 2'd1;
              fs_out = 4'd0;
              nstate = S_INF;
            end
            OP_JMP: begin
              ps_out = 2'd3;
              fs_out = 4'd0;
              nstate = S_INF;
            end
            OP_HAL: begin
              ps_out = 2'd1;
              nstate = S_HLT;
            end
            OP_RTI: begin
              pc_epc_out = 1'b1;
              isr_clr    = 1'b1;
              nstate     = S_INF;
            end
            OP_XXL: begin
              rw_out = 1'b1;
              ps_out = 2'd1;
              fs_out = 4'b0011;
              rs_out = {TMP, R_ONE, R_TWO};
              nstate = S_XL1;
            end
            default: nstate = S_HLT;
          endcase
        end
        // Memory/I/O ops hold their controls until the ready cycle commits them
        if (wait_op) begin
          if (rdy) begin
            rw_out = wb_op;
            ps_out = 2'd1;
            nstate = S_INF;
          end else begin
            wait_cyc = 1'b1;
          end
        end
      end
      S_XL1: begin
        rw_out = 1'b1;
        ps_out = 2'd1;
        fs_out = 4'b0010;
        rs_out = {R_ZER, R_ZER, TMP};
        nstate = S_INF;
      end
      S_INT: begin
        epc_we_out  = 1'b1;
        pc_vec_out  = 1'b1;
        irq_ack_out = 1'b1;
        isr_set     = 1'b1;
        nstate      = S_INF;
      end
      S_HLT: begin
        if (!err_r && irq_ok) nstate = S_INT;
      end
      default: nstate = S_RST;
    endcase

    // Watchdog expiry overrides whatever the wait state would have done
    if (wait_cyc && (wcnt == WD_MAX)) begin
      err_set = 1'b1;
      nstate  = S_HLT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RST;
      isr_r <= 1'b0;
      err_r <= 1'b0;
      wcnt  <= '0;
    end else begin
      state <= nstate;
      if (isr_set)      isr_r <= 1'b1;
      else if (isr_clr) isr_r <= 1'b0;
      if (err_set) err_r <= 1'b1;
      wcnt <= (wait_cyc && (nstate == state)) ? wcnt + 1'b1 : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cu_mc.sv
// tb_cu_mc: randomized bench for cu_mc against an instruction-level reference model.
`default_nettype none

module tb_cu_mc;
  import mycpu_pkg::*;

  localparam int RA_W    = 4;
  localparam int TIMEOUT = 4;
  localparam int IW      = 7 + 3*RA_W;
  localparam int RSW     = 3*(RA_W+1);

  logic clk, rst;
  logic [IW-1:0] ins;
  logic z, n, mem_rdy, io_rdy, irq, irq_en;
  logic il, rw, mm, mb, wen, iom, vec, epc, epcwe, ack, halted, err;
  logic [1:0] ps, md;
  logic [RSW-1:0] rs;
  logic [3:0] fs;

  typedef struct packed {
    logic           il;
    logic [1:0]     ps;
    logic           rw;
    logic [RSW-1:0] rs;
    logic           mm;
    logic [1:0]     md;
    logic           mb;
    logic [3:0]     fs;
    logic           wen;
    logic           iom;
    logic           vec;
    logic           epc;
    logic           epcwe;
    logic           ack;
    logic           halted;
    logic           err;
  } outs_t;

  outs_t dut_o, exp_o, seen, dflt;

  cu_mc #(.RA_W(RA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ins_in(ins), .z_in(z), .n_in(n),
    .mem_rdy_in(mem_rdy), .io_rdy_in(io_rdy), .irq_in(irq), .irq_en_in(irq_en),
    .il_out(il), .ps_out(ps), .rw_out(rw), .rs_out(rs), .mm_out(mm), .md_out(md),
    .mb_out(mb), .fs_out(fs), .wen_out(wen), .iom_out(iom), .pc_vec_out(vec),
    .pc_epc_out(epc), .epc_we_out(epcwe), .irq_ack_out(ack),
    .halted_out(halted), .err_out(err)
  );

  assign dut_o = {il, ps, rw, rs, mm, md, mb, fs, wen, iom, vec, epc, epcwe, ack, halted, err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model phases of the instruction life cycle
  localparam int M_BOOT = 0, M_FETCH = 1, M_EXEC = 2, M_XL2 = 3, M_TRAP = 4, M_STOP = 5;
  localparam int K_REG = 0, K_LOAD = 1, K_STORE = 2, K_IN = 3, K_OUT = 4, K_BR = 5,
                 K_JMP = 6, K_HALT = 7, K_RTI = 8, K_XXL = 9, K_BAD = 10;

  int  mode, nmode, waited, nwaited;
  bit  in_isr, nisr, fault, nfault, valid;
  int  n_cmp, n_bad;

  function automatic int op_kind(logic [6:0] op);
    if (op[6:4] == 3'b000 || op == OP_LDI || op == OP_ADI) return K_REG;
    if (op == OP_LD)  return K_LOAD;
    if (op == OP_ST)  return K_STORE;
    if (op == OP_IOR) return K_IN;
    if (op == OP_IOW) return K_OUT;
    if (op == OP_BRZ || op == OP_BRN) return K_BR;
    if (op == OP_JMP) return K_JMP;
    if (op == OP_HAL) return K_HALT;
    if (op == OP_RTI) return K_RTI;
    if (op == OP_XXL) return K_XXL;
    return K_BAD;
  endfunction

  task automatic model_eval();
    logic [6:0] op;
    logic [RA_W-1:0] fa, fb, fc;
    logic [RA_W:0] tmp;
    bit elig, stalled, ready, is_io;
    int k;
    op = ins[IW-1:IW-7];
    fa = ins[3*RA_W-1:2*RA_W];
    fb = ins[2*RA_W-1:RA_W];
    fc = ins[RA_W-1:0];
    tmp = '1;
    exp_o = '0;
    exp_o.wen = 1'b1;
    exp_o.halted = (mode == M_STOP);
    exp_o.err = fault;
    elig = irq && irq_en && !in_isr;
    stalled = 0;
    nmode = mode; nisr = in_isr; nfault = fault;
    case (mode)
      M_BOOT: nmode = M_FETCH;
      M_FETCH: begin
        if (elig) nmode = M_TRAP;
        else begin
          exp_o.mm = 1'b1;
          exp_o.il = mem_rdy;
          if (mem_rdy) nmode = M_EXEC; else stalled = 1;
        end
      end
      M_EXEC: begin
        k = op_kind(op);
        exp_o.fs = op[3:0];
        exp_o.rs = {1'b0, fa, 1'b0, fb, 1'b0, fc};
        if (k == K_REG) begin
          exp_o.rw = 1; exp_o.ps = 1;
          exp_o.mb = (op == OP_LDI || op == OP_ADI);
          nmode = M_FETCH;
        end else if (k >= K_LOAD && k <= K_OUT) begin
          is_io = (k == K_IN || k == K_OUT);
          ready = is_io ? io_rdy : mem_rdy;
          exp_o.md  = (k == K_LOAD) ? 2'd1 : (k == K_IN) ? 2'd2 : 2'd0;
          exp_o.wen = !(k == K_STORE || k == K_OUT);
          exp_o.iom = is_io;
          if (is_io) exp_o.fs = 0;
          if (ready) begin
            exp_o.rw = (k == K_LOAD || k == K_IN);
            exp_o.ps = 1;
            nmode = M_FETCH;
          end else stalled = 1;
        end else if (k == K_BR) begin
          exp_o.ps = ((op == OP_BRZ) ? z : n) ? 2'd2 : 2'd1;
          exp_o.fs = 0;
          nmode = M_FETCH;
        end else if (k == K_JMP) begin
          exp_o.ps = 3; exp_o.fs = 0; nmode = M_FETCH;
        end else if (k == K_HALT) begin
          exp_o.ps = 1; nmode = M_STOP;
        end else if (k == K_RTI) begin
          exp_o.epc = 1; nisr = 0; nmode = M_FETCH;
        end else if (k == K_XXL) begin
          exp_o.rw = 1; exp_o.ps = 1; exp_o.fs = 4'd3;
          exp_o.rs = {tmp, (RA_W+1)'(1), (RA_W+1)'(2)};
          nmode = M_XL2;
        end else nmode = M_STOP;
      end
      M_XL2: begin
        exp_o.rw = 1; exp_o.ps = 1; exp_o.fs = 4'd2;
        exp_o.rs = {(RA_W+1)'(0), (RA_W+1)'(0), tmp};
        nmode = M_FETCH;
      end
      M_TRAP: begin
        exp_o.epcwe = 1; exp_o.vec = 1; exp_o.ack = 1;
        nisr = 1; nmode = M_FETCH;
      end
      default: if (!fault && elig) nmode = M_TRAP;
    endcase
    if (stalled) begin
      if (waited == TIMEOUT) begin nmode = M_STOP; nfault = 1; nwaited = 0; end
      else nwaited = waited + 1;
    end else nwaited = 0;
    if (rst) begin nmode = M_BOOT; nisr = 0; nfault = 0; nwaited = 0; end
  endtask

  task automatic cyc(input bit r, input logic [IW-1:0] i, input bit m, input bit io,
                     input bit q, input bit qe, input bit zz, input bit nn);
    rst = r; ins = i; mem_rdy = m; io_rdy = io; irq = q; irq_en = qe; z = zz; n = nn;
    #1;
    model_eval();
    if (valid) begin
      n_cmp++;
      if (dut_o !== exp_o) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t mode=%0d: got %h expected %h", $time, mode, dut_o, exp_o);
      end
    end
    seen = dut_o;
    @(posedge clk);
    mode = nmode; in_isr = nisr; fault = nfault; waited = nwaited;
    if (r) valid = 1;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [IW-1:0] mk(logic [6:0] op, int a, int b, int c);
    return {op, a[RA_W-1:0], b[RA_W-1:0], c[RA_W-1:0]};
  endfunction

  logic [6:0] op_tab [0:15];

  initial begin
    int stopped, drought;
    logic [IW-1:0] cur;
    logic [6:0] pick;
    bit rr, mr, ir;
    op_tab = '{OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_LDI, OP_ADI, OP_LD, OP_ST,
               OP_IOR, OP_IOW, OP_BRZ, OP_BRN, OP_JMP, OP_HAL, OP_RTI, OP_XXL};
    n_cmp = 0; n_bad = 0; valid = 0;
    mode = M_BOOT; in_isr = 0; fault = 0; waited = 0;
    dflt = '0; dflt.wen = 1'b1;
    rst = 1; ins = '0; mem_rdy = 0; io_rdy = 0; irq = 0; irq_en = 0; z = 0; n = 0;
    @(negedge clk);

    // Directed: hand-computed expectations
    cyc(1, '0, 0, 0, 0, 0, 0, 0);
    cyc(1, '0, 0, 0, 0, 0, 0, 0);
    cyc(0, mk(OP_ADD, 1, 2, 3), 1, 1, 0, 0, 0, 0);
    chk("reset_outs", 64'(seen), 64'(dflt));
    cyc(0, mk(OP_ADD, 1, 2, 3), 1, 1, 0, 0, 0, 0);
    chk("fetch_il_mm", {seen.il, seen.mm}, 2'b11);
    cyc(0, mk(OP_ADD, 1, 2, 3), 1, 1, 0, 0, 0, 0);
    chk("add_rw_ps", {seen.rw, seen.ps}, 3'b101);
    chk("add_rs", seen.rs, 15'b00001_00010_00011);
    cyc(0, mk(OP_LD, 4, 5, 0), 1, 1, 0, 0, 0, 0);
    chk("add_back_inf", seen.il, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, mk(OP_LD, 4, 5, 0), 0, 1, 0, 0, 0, 0);
      chk("ld_wait", {seen.rw, seen.ps, seen.md}, 5'b0_00_01);
    end
    cyc(0, mk(OP_LD, 4, 5, 0), 1, 1, 0, 0, 0, 0);
    chk("ld_ready", {seen.rw, seen.ps, seen.md}, 5'b1_01_01);
    cyc(0, mk(OP_XXL, 0, 0, 0), 1, 1, 0, 0, 0, 0);
    cyc(0, mk(OP_XXL, 0, 0, 0), 1, 1, 0, 0, 0, 0);
    chk("xxl_step0", {seen.rs, seen.fs}, {15'b11111_00001_00010, 4'b0011});
    cyc(0, mk(OP_XXL, 0, 0, 0), 1, 1, 0, 0, 0, 0);
    chk("xxl_step1", {seen.rs, seen.fs}, {15'b00000_00000_11111, 4'b0010});
    cyc(0, mk(OP_RTI, 0, 0, 0), 1, 1, 1, 1, 0, 0);
    chk("irq_wins", {seen.il, seen.mm}, 2'b00);
    cyc(0, mk(OP_RTI, 0, 0, 0), 1, 1, 1, 1, 0, 0);
    chk("int_pulse", {seen.epcwe, seen.vec, seen.ack}, 3'b111);
    cyc(0, mk(OP_RTI, 0, 0, 0), 1, 1, 1, 1, 0, 0);
    chk("irq_masked", {seen.il, seen.ack}, 2'b10);
    cyc(0, mk(OP_RTI, 0, 0, 0), 1, 1, 0, 0, 0, 0);
    chk("rti", {seen.epc, seen.ps}, 3'b100);
    cyc(0, mk(OP_HAL, 0, 0, 0), 1, 1, 0, 0, 0, 0);
    cyc(0, mk(OP_HAL, 0, 0, 0), 1, 1, 0, 0, 0, 0);
    chk("hal_ps", seen.ps, 2'd1);
    cyc(0, mk(OP_ST, 0, 0, 0), 1, 1, 1, 1, 0, 0);
    chk("hlt_halted", seen.halted, 1);
    cyc(0, mk(OP_ST, 0, 0, 0), 1, 1, 0, 0, 0, 0);
    chk("hlt_to_int", seen.ack, 1);
    cyc(0, mk(OP_ST, 0, 0, 0), 1, 1, 0, 0, 0, 0);
    chk("st_fetch", seen.il, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, mk(OP_ST, 0, 0, 0), 0, 1, 0, 0, 0, 0);
      chk("st_wait", {seen.wen, seen.ps, seen.halted}, 4'b0_00_0);
    end
    cyc(0, mk(OP_ST, 0, 0, 0), 1, 1, 1, 1, 0, 0);
    chk("timeout_hlt", {seen.halted, seen.err}, 2'b11);
    cyc(0, mk(OP_ST, 0, 0, 0), 1, 1, 1, 1, 0, 0);
    chk("err_ignores_irq", {seen.halted, seen.ack}, 2'b10);
    cyc(1, mk(OP_ST, 0, 0, 0), 1, 1, 1, 1, 0, 0);
    cyc(0, mk(OP_ADD, 0, 0, 0), 1, 1, 0, 0, 0, 0);
    chk("reset_after_err", 64'(seen), 64'(dflt));

    // Randomized run
    stopped = 0; drought = 0; cur = '0;
    for (int c = 0; c < 3000; c++) begin
      if (mode != M_EXEC && mode != M_XL2) begin
        pick = ($urandom_range(9) == 0) ? 7'($urandom) : op_tab[$urandom_range(15)];
        cur = {pick, RA_W'($urandom), RA_W'($urandom), RA_W'($urandom)};
      end
      if (drought == 0 && $urandom_range(99) < 3) drought = 6;
      if (drought > 0) begin drought--; mr = 0; ir = 0; end
      else begin mr = ($urandom_range(9) < 7); ir = ($urandom_range(9) < 7); end
      stopped = (mode == M_STOP) ? stopped + 1 : 0;
      rr = (stopped > 5) || ($urandom_range(99) == 0);
      cyc(rr, cur, mr, ir, $urandom_range(9) < 2, $urandom_range(9) < 8,
          1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
